sequenceur_lancer: RTL and testbench
====================================

// Module: sequenceur_lancer
// PURPOSE
//  Roll controller sitting after the die-type selector. Gates "next die type" requests while busy.
//  Latches min/faces of the selected die, runs a spinning animation while the roll button is held,
//  then reduces a free-running LFSR sample into [min_de, min_de+faces_de-1].
//  Presents result and animation value for BCD/7-seg display.
// PARAMETERS
//  GRAINE     16'hACE1  LFSR reset value; value 0 is replaced by 16'hACE1
//  ROULE_MIN  32        minimum cycles spent in ROULE (>=1)
//  ANIM_DIV   4         cycles per animation step (>=1)
// PORTS
//  horloge        in   1  single clock, all state on rising edge
//  raz            in   1  synchronous reset, active-high
//  lancer         in   1  roll button, level, already synchronised; rising edge starts a roll
//  suivant_in     in   1  next-die-type request, 1-cycle pulse
//  min_de         in   7  lowest face of selected die
//  faces_de       in   7  face count of selected die
//  suivant_out    out  1  pulse forwarded to the die-type counter
//  affichage      out  7  value to display (animation or result)
//  resultat       out  7  last roll result
//  resultat_valide out 1  resultat holds a roll for the current die type
//  occupe         out  1  high in ROULE and REDUIT
//  erreur         out  1  high when the last roll latched faces_de==0
// BEHAVIOUR
//  Reset (raz=1 at edge): state REPOS, all outputs 0, LFSR=GRAINE, edge register=0. Applies mid-roll.
//  LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle in every state.
//  lancer_front = lancer & ~lancer_q, where lancer_q is lancer registered.
//  Internal regs: min_l, faces_l (7b), cpt (roll cycles), div (anim), reste (8b).
//  REPOS: suivant_out=suivant_in (combinational pass-through).
//   - If lancer_front: latch min_l/faces_l, cpt=0, affichage<=min_de, go ROULE.
//  ROULE: occupe=1, suivant_out=0; suivant_in is dropped, not queued.
//   - min_de/faces_de changes are ignored.
//   - Each cycle cpt++ (saturating).
//   - Every ANIM_DIV cycles affichage steps by +1, wrapping from min_l+faces_l-1 to min_l.
//   - faces_l<=1: affichage stays min_l.
//   - Exit when lancer==0 and cpt>=ROULE_MIN-1: reste<=lfsr[7:0], go REDUIT.
//  REDUIT: occupe=1, suivant_out=0. One cycle per step:
//   - faces_l==0: resultat<=min_l, erreur<=1, go AFFICHE.
//   - else if reste>=faces_l: reste<=reste-faces_l.
//   - else: resultat<=min_l+reste (7b, truncated), erreur<=0, resultat_valide<=1, go AFFICHE.
//   - Cycles spent = floor(sample/faces_l)+1 (max 128 for faces 2; faces 1 -> 256).
//  AFFICHE: affichage=resultat, occupe=0.
//   - suivant_in: forward pulse same cycle, resultat_valide<=0, affichage<=0, go REPOS.
//   - Else lancer_front: new roll exactly as from REPOS; resultat_valide stays 1 until overwritten.
//   - Simultaneous suivant_in and lancer_front: suivant wins, no roll starts.
//  lancer already high at reset release: no front, stays REPOS until released and re-pressed.
//  Inputs are guaranteed min_de+faces_de-1 <= 127; outside this, the result wraps (7-bit).
// TESTING
//  1. raz mid-ROULE and mid-REDUIT -> next cycle all outputs 0, state REPOS, LFSR=GRAINE.
//  2. min=1,faces=6, lancer pulse 1 cycle -> occupe ROULE_MIN cycles; resultat = 1+(sample mod 6).
//     Result matches LFSR model, in [1..6]; REDUIT length = floor(sample/6)+1.
//  3. min=1,faces=20, lancer held 200 cycles -> affichage steps every 4 cycles, wraps 20->1.
//     No exit while held.
//  4. suivant_in pulses during ROULE/REDUIT -> suivant_out stays 0.
//     In REPOS/AFFICHE -> same-cycle echo; in AFFICHE resultat_valide drops.
//  5. faces=0,min=5 -> resultat=5, erreur=1, valide=0. faces=1,min=3 -> resultat=3, erreur=0.
//  6. Same-cycle suivant_in+lancer_front in AFFICHE -> suivant_out=1, state REPOS, no roll.
//     1000 random rolls min=0,faces=100 -> all in [0..99].

Source files
------------

// File: rtl/sequenceur_lancer.sv
// Roll controller placed after the die-type selector.
// It latches the selected die when the roll button rises, spins an animated
// value while the button is held, then reduces a free-running LFSR sample into
// [min, min+faces-1] by repeated subtraction. It also gates "next die type"
// requests while a roll is in flight.
module sequenceur_lancer #(
  parameter logic [15:0] GRAINE    = 16'hACE1,
  parameter int          ROULE_MIN = 32,
  parameter int          ANIM_DIV  = 4
) (
  input  logic       horloge,
  input  logic       raz,
  input  logic       lancer,
  input  logic       suivant_in,
  input  logic [6:0] min_de,
  input  logic [6:0] faces_de,
  output logic       suivant_out,
  output logic [6:0] affichage,
  output logic [6:0] resultat,
  output logic       resultat_valide,
  output logic       occupe,
  output logic       erreur
);

  // An all-zero seed would lock the LFSR, so it falls back to the default seed.
  localparam logic [15:0] GRAINE_EFF = (GRAINE == 16'h0000) ? 16'hACE1 : GRAINE;
  localparam int CPT_W = $clog2(ROULE_MIN) + 1;
  localparam int DIV_W = $clog2(ANIM_DIV) + 1;

  typedef enum logic [1:0] {
    REPOS   = 2'd0,
    ROULE   = 2'd1,
    REDUIT  = 2'd2,
    AFFICHE = 2'd3
  } etat_t;

  etat_t             etat_q, etat_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              lancer_q;
  logic              arme_q, arme_d;
  logic [6:0]        min_q, min_d;
  logic [6:0]        faces_q, faces_d;
  logic [CPT_W-1:0]  cpt_q, cpt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        reste_q, reste_d;
  logic [6:0]        affichage_q, affichage_d;
  logic [6:0]        resultat_q, resultat_d;
  logic              valide_q, valide_d;
  logic              erreur_q, erreur_d;

  logic              lancer_front;
  logic              demarrer;
  logic [6:0]        anim_haut;
  logic [6:0]        somme;

  // Galois LFSR (mask 16'hB400) advancing on every cycle in every state.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
    end
  end

  // Rising edge of the roll button; arme_q suppresses the edge when the
  // button is already held as reset is released, until it is seen low once.
  always_comb begin
    arme_d       = arme_q | ~lancer;
    lancer_front = lancer & ~lancer_q & arme_q;
  end

  // Next-state and output decode of the roll sequencer.
  always_comb begin
    etat_d      = etat_q;
    min_d       = min_q;
    faces_d     = faces_q;
    cpt_d       = cpt_q;
    div_d       = div_q;
    reste_d     = reste_q;
    affichage_d = affichage_q;
    resultat_d  = resultat_q;
    valide_d    = valide_q;
    erreur_d    = erreur_q;
    suivant_out = 1'b0;
    occupe      = 1'b0;
    demarrer    = 1'b0;
    anim_haut   = min_q + faces_q - 7'd1;
    somme       = min_q + reste_q[6:0];

    case (etat_q)
      REPOS: begin
        suivant_out = suivant_in;
        if (lancer_front) begin
          demarrer = 1'b1;
        end
      end

      ROULE: begin
        occupe = 1'b1;
        if (cpt_q != {CPT_W{1'b1}}) begin
          cpt_d = cpt_q + 1'b1;
        end
        if (div_q == DIV_W'(ANIM_DIV - 1)) begin
          div_d = '0;
          if (faces_q <= 7'd1) begin
            affichage_d = min_q;
          end else if (affichage_q == anim_haut) begin
            affichage_d = min_q;
          end else begin
            affichage_d = affichage_q + 7'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
        if (!lancer && (cpt_q >= CPT_W'(ROULE_MIN - 1))) begin
          reste_d = lfsr_q[7:0];
          etat_d  = REDUIT;
        end
      end

      REDUIT: begin
        occupe = 1'b1;
        if (faces_q == 7'd0) begin
          resultat_d  = min_q;
          affichage_d = min_q;
          erreur_d    = 1'b1;
          valide_d    = 1'b0;
          etat_d      = AFFICHE;
        end else if (reste_q >= {1'b0, faces_q}) begin
          reste_d = reste_q - {1'b0, faces_q};
        end else begin
          resultat_d  = somme;
          affichage_d = somme;
          erreur_d    = 1'b0;
          valide_d    = 1'b1;
          etat_d      = AFFICHE;
        end
      end

      AFFICHE: begin
        suivant_out = suivant_in;
        if (suivant_in) begin
          valide_d    = 1'b0;
          affichage_d = 7'd0;
          etat_d      = REPOS;
        end else if (lancer_front) begin
          demarrer = 1'b1;
        end
      end

      default: begin
        etat_d = REPOS;
      end
    endcase

    if (demarrer) begin
      min_d       = min_de;
      faces_d     = faces_de;
      cpt_d       = '0;
      div_d       = '0;
      affichage_d = min_de;
      etat_d      = ROULE;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge horloge) begin
    if (raz) begin
      etat_q      <= REPOS;
      lfsr_q      <= GRAINE_EFF;
      lancer_q    <= 1'b0;
      arme_q      <= 1'b0;
      min_q       <= '0;
      faces_q     <= '0;
      cpt_q       <= '0;
      div_q       <= '0;
      reste_q     <= '0;
      affichage_q <= '0;
      resultat_q  <= '0;
      valide_q    <= 1'b0;
      erreur_q    <= 1'b0;
    end else begin
      etat_q      <= etat_d;
      lfsr_q      <= lfsr_d;
      lancer_q    <= lancer;
      arme_q      <= arme_d;
      min_q       <= min_d;
      faces_q     <= faces_d;
      cpt_q       <= cpt_d;
      div_q       <= div_d;
      reste_q     <= reste_d;
      affichage_q <= affichage_d;
      resultat_q  <= resultat_d;
      valide_q    <= valide_d;
      erreur_q    <= erreur_d;
    end
  end

  assign affichage       = affichage_q;
  assign resultat        = resultat_q;
  assign resultat_valide = valide_q;
  assign erreur          = erreur_q;

endmodule

// File: tb/tb_sequenceur_lancer.sv
// Bench for the roll sequencer: directed steps plus randomized rolls, each
// checked against a cycle-count model of the roll (sample timing, remainder
// arithmetic, animation position) built from the behavioural rules.
module tb_sequenceur_lancer;

  localparam int ROULE_MIN = 32;
  localparam int ANIM_DIV  = 4;

  logic       horloge = 1'b0;
  logic       raz = 1'b1;
  logic       lancer = 1'b0;
  logic       suivant_in = 1'b0;
  logic [6:0] min_de = 7'd0;
  logic [6:0] faces_de = 7'd0;
  logic       suivant_out;
  logic [6:0] affichage;
  logic [6:0] resultat;
  logic       resultat_valide;
  logic       occupe;
  logic       erreur;

  int checks = 0;
  int errors = 0;

  logic [15:0] mlfsr;
  logic [6:0]  dernier;

  sequenceur_lancer #(
    .GRAINE(16'hACE1),
    .ROULE_MIN(ROULE_MIN),
    .ANIM_DIV(ANIM_DIV)
  ) dut (
    .horloge(horloge),
    .raz(raz),
    .lancer(lancer),
    .suivant_in(suivant_in),
    .min_de(min_de),
    .faces_de(faces_de),
    .suivant_out(suivant_out),
    .affichage(affichage),
    .resultat(resultat),
    .resultat_valide(resultat_valide),
    .occupe(occupe),
    .erreur(erreur)
  );

  // Free-running clock.
  always #5 horloge = ~horloge;

  // Polynomial-division view of the Galois LFSR: drop the low bit and, when
  // it was set, fold the feedback polynomial back in.
  function automatic logic [15:0] lfsrSuivant(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference LFSR: counts cycles since reset in step with the design.
  always @(posedge horloge) begin
    if (raz) mlfsr <= 16'hACE1;
    else     mlfsr <= lfsrSuivant(mlfsr);
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic s, input logic [6:0] mn, input logic [6:0] fc);
    lancer     = l;
    suivant_in = s;
    min_de     = mn;
    faces_de   = fc;
  endtask

  task automatic step();
    @(posedge horloge);
    #1;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_suivant_out"}, 16'(suivant_out), 16'd0);
    checkOutput({tag, "_affichage"}, 16'(affichage), 16'd0);
    checkOutput({tag, "_resultat"}, 16'(resultat), 16'd0);
    checkOutput({tag, "_valide"}, 16'(resultat_valide), 16'd0);
    checkOutput({tag, "_occupe"}, 16'(occupe), 16'd0);
    checkOutput({tag, "_erreur"}, 16'(erreur), 16'd0);
  endtask

  // One complete roll. hold = number of edges the button is seen high
  // (including the starting one). abortMode 1 resets mid-spin, 2 resets
  // on the first reduction cycle.
  task automatic doRoll(input logic [6:0] mn, input logic [6:0] fc, input int hold,
                        input int abortMode, input bit pulseSuivant, output logic [6:0] res);
    int   rc;
    int   n;
    int   s;
    int   expRes;
    int   expAff;
    bit   exitNow;
    bit   sorti;
    res = 7'd0;
    s = 0;
    sorti = 1'b0;
    applyStimulus(1'b1, 1'b0, mn, fc);
    step();
    checkOutput("start_occupe", 16'(occupe), 16'd1);
    checkOutput("start_affichage", 16'(affichage), 16'(mn));
    rc = 0;
    for (int guard = 0; guard < 4000; guard++) begin
      if (rc >= hold - 1) lancer = 1'b0;
      min_de   = 7'($urandom);
      faces_de = 7'($urandom);
      suivant_in = pulseSuivant ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checkOutput("roule_suivant_out", 16'(suivant_out), 16'd0);
      if (abortMode == 1 && rc == 5) begin
        applyStimulus(1'b0, 1'b0, 7'd0, 7'd0);
        raz = 1'b1;
        step();
        checkZero("raz_roule");
        raz = 1'b0;
        step();
        return;
      end
      exitNow = !lancer && (rc >= ROULE_MIN - 1);
      if (exitNow) s = int'(mlfsr[7:0]);
      step();
      rc++;
      if (exitNow) begin
        sorti = 1'b1;
        break;
      end
      checkOutput("roule_occupe", 16'(occupe), 16'd1);
      expAff = (fc >= 7'd2) ? (int'(mn) + (rc / ANIM_DIV) % int'(fc)) : int'(mn);
      checkOutput("roule_anim", 16'(affichage), 16'(expAff & 127));
    end
    if (!sorti) begin
      checks++;
      errors++;
      $error("[TB] FAIL roule_timeout: observed no exit expected exit after %0d cycles", ROULE_MIN);
      return;
    end
    if (abortMode == 2) begin
      applyStimulus(1'b0, 1'b0, 7'd0, 7'd0);
      raz = 1'b1;
      step();
      checkZero("raz_reduit");
      raz = 1'b0;
      step();
      return;
    end
    n = (fc == 7'd0) ? 1 : (s / int'(fc)) + 1;
    for (int i = 0; i < n; i++) begin
      checkOutput("reduit_occupe", 16'(occupe), 16'd1);
      suivant_in = pulseSuivant ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checkOutput("reduit_suivant_out", 16'(suivant_out), 16'd0);
      step();
    end
    suivant_in = 1'b0;
    expRes = (fc == 7'd0) ? int'(mn) : ((int'(mn) + s % int'(fc)) & 127);
    checkOutput("fin_occupe", 16'(occupe), 16'd0);
    checkOutput("fin_resultat", 16'(resultat), 16'(expRes));
    checkOutput("fin_affichage", 16'(affichage), 16'(expRes));
    checkOutput("fin_valide", 16'(resultat_valide), (fc != 7'd0) ? 16'd1 : 16'd0);
    checkOutput("fin_erreur", 16'(erreur), (fc == 7'd0) ? 16'd1 : 16'd0);
    res = resultat;
  endtask

  // Directed sequence followed by randomized rolls.
  initial begin
    int mn;
    int fc;
    applyStimulus(1'b0, 1'b0, 7'd0, 7'd0);
    raz = 1'b1;
    step();
    step();
    checkZero("reset");
    raz = 1'b0;
    step();

    // Pass-through while idle.
    suivant_in = 1'b1;
    #1;
    checkOutput("repos_echo", 16'(suivant_out), 16'd1);
    step();
    suivant_in = 1'b0;
    #1;
    checkOutput("repos_echo_off", 16'(suivant_out), 16'd0);
    checkOutput("repos_occupe", 16'(occupe), 16'd0);

    // d6 with a single-cycle press and suivant noise during the roll.
    doRoll(7'd1, 7'd6, 1, 0, 1'b1, dernier);
    checkOutput("d6_range", 16'((dernier >= 7'd1) && (dernier <= 7'd6)), 16'd1);

    // Request in the result state: echoed, result invalidated, display cleared.
    suivant_in = 1'b1;
    #1;
    checkOutput("affiche_echo", 16'(suivant_out), 16'd1);
    step();
    suivant_in = 1'b0;
    checkOutput("affiche_suivant_valide", 16'(resultat_valide), 16'd0);
    checkOutput("affiche_suivant_aff", 16'(affichage), 16'd0);
    checkOutput("affiche_suivant_occupe", 16'(occupe), 16'd0);

    // Long hold: animation wraps 20 -> 1 and never exits while held.
    doRoll(7'd1, 7'd20, 200, 0, 1'b0, dernier);

    // Degenerate dice.
    doRoll(7'd5, 7'd0, 3, 0, 1'b0, dernier);
    doRoll(7'd3, 7'd1, 1, 0, 1'b0, dernier);

    // Simultaneous request and press in the result state: request wins.
    lancer = 1'b1;
    suivant_in = 1'b1;
    #1;
    checkOutput("simul_echo", 16'(suivant_out), 16'd1);
    step();
    suivant_in = 1'b0;
    checkOutput("simul_occupe", 16'(occupe), 16'd0);
    checkOutput("simul_valide", 16'(resultat_valide), 16'd0);
    step();
    step();
    checkOutput("simul_no_roll", 16'(occupe), 16'd0);
    lancer = 1'b0;
    step();

    // Reset mid-spin and mid-reduction; following rolls restart the LFSR model.
    doRoll(7'd2, 7'd10, 50, 1, 1'b0, dernier);
    doRoll(7'd1, 7'd6, 1, 0, 1'b0, dernier);
    doRoll(7'd0, 7'd1, 1, 2, 1'b0, dernier);
    doRoll(7'd1, 7'd6, 1, 0, 1'b0, dernier);

    // Button held through reset release must not start a roll.
    lancer = 1'b1;
    raz = 1'b1;
    step();
    raz = 1'b0;
    step();
    step();
    checkOutput("held_at_reset", 16'(occupe), 16'd0);
    lancer = 1'b0;
    step();

    // 1000 random d100 rolls (faces 100, min 0).
    for (int k = 0; k < 1000; k++) begin
      doRoll(7'd0, 7'd100, int'($urandom_range(1, 8)), 0, 1'($urandom_range(0, 1)), dernier);
      checkOutput("d100_range", 16'(dernier < 7'd100), 16'd1);
      if ($urandom_range(0, 7) == 0) begin
        suivant_in = 1'b1;
        step();
        suivant_in = 1'b0;
      end
    end

    // Random legal dice.
    for (int k = 0; k < 100; k++) begin
      fc = int'($urandom_range(0, 40));
      mn = (fc == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 128 - fc));
      doRoll(7'(mn), 7'(fc), int'($urandom_range(1, 40)), 0, 1'b1, dernier);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
